// File: rtl/wb_pkg.sv
// wb_pkg: constants and helpers shared by the Wishbone RAM responder and its stall generator.
//   LFSR_SEED   - reset value of the pseudo-random stall LFSR
//   LFSR_TAPS   - feedback mask for taps 16,14,13,11 (bit n-1 for tap n)
//   MAX_LATENCY - deepest supported response pipeline
package wb_pkg;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int unsigned MAX_LATENCY = 4;

    // One step of the 16-bit Fibonacci LFSR: shift left, feedback enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wb_stall_gen.sv
// wb_stall_gen: STALL pattern for the Wishbone RAM responder.
//   clk_i   - bus clock
//   rst_i   - synchronous active-high reset
//   cyc_i   - bus cycle active
//   stall_o - request not accepted this cycle (depends only on state and cyc_i)
// Periodic mode stalls one cycle in every STALL_PERIOD cycles of an active CYC;
// random mode stalls when the two LSBs of an LFSR are both set (about 25 %).
module wb_stall_gen
    import wb_pkg::*;
#(
    parameter int unsigned STALL_PERIOD = 0,
    parameter bit          STALL_RANDOM = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cyc_i,
    output logic stall_o
);

    localparam bit              PeriodEn = (STALL_PERIOD >= 2);
    localparam int unsigned     CntW     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast  = PeriodEn ? CntW'(STALL_PERIOD - 1) : '0;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;

    // Counter restarts at 0 whenever CYC is low; LFSR only runs during CYC.
    always_comb begin
        cnt_d  = '0;
        lfsr_d = lfsr_q;
        if (cyc_i) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (PeriodEn && (cnt_q != CntLast)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        stall_o = 1'b0;
        if (cyc_i) begin
            if (STALL_RANDOM) begin
                stall_o = lfsr_q[0] & lfsr_q[1];
            end else if (PeriodEn) begin
                stall_o = (cnt_q == CntLast);
            end
        end
    end

endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: pipelined Wishbone B4 word-RAM responder.
//   clk_i   - bus clock
//   rst_i   - synchronous active-high reset (RAM contents are kept)
//   cyc_i   - bus cycle valid
//   stb_i   - request strobe
//   we_i    - 1 = write
//   adr_i   - word address (AW bits)
//   dat_m_i - write data from the master
//   dat_s_o - read data to the master, valid with ack_o (0 for write acks)
//   stall_o - request not accepted this cycle
//   ack_o   - one pulse per accepted request, LATENCY cycles after accept
// LATENCY outside 1..MAX_LATENCY is clamped into that range.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int unsigned AW           = 13,
    parameter int unsigned DW           = 16,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STALL_PERIOD = 0,
    parameter bit          STALL_RANDOM = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] dat_m_i,
    output logic [DW-1:0] dat_s_o,
    output logic          stall_o,
    output logic          ack_o
);

    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned Lat   = (LATENCY < 1) ? 1 :
                                    ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);

    logic [DW-1:0] mem_q [Depth];
    logic          accept;
    logic          v_q [Lat];
    logic          v_d [Lat];
    logic [DW-1:0] d_q [Lat];
    logic [DW-1:0] d_d [Lat];

    wb_stall_gen #(
        .STALL_PERIOD(STALL_PERIOD),
        .STALL_RANDOM(STALL_RANDOM)
    ) u_stall_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cyc_i  (cyc_i),
        .stall_o(stall_o)
    );

    assign accept = cyc_i & stb_i & ~stall_o;

    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            mem_q[adr_i] <= dat_m_i;
        end
    end

    // Stage 0 captures the read word at the accept edge; later stages only
    // survive while CYC stays high, so an abort discards everything in flight.
    always_comb begin
        v_d[0] = accept;
        d_d[0] = (accept && !we_i) ? mem_q[adr_i] : '0;
        for (int i = 1; i < int'(Lat); i++) begin
            v_d[i] = v_q[i-1] & cyc_i;
            d_d[i] = d_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Lat); i++) begin
                v_q[i] <= 1'b0;
                d_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Lat); i++) begin
                v_q[i] <= v_d[i];
                d_q[i] <= d_d[i];
            end
        end
    end

    assign ack_o   = v_q[Lat-1];
    assign dat_s_o = d_q[Lat-1];

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: self-checking bench for wb_ram_slave.
// Five instances cover the parameter sets: 0 default, 1 LATENCY=3, 2 STALL_PERIOD=4,
// 3 STALL_RANDOM with LATENCY=2, 4 LATENCY=4. One instance is exercised at a time;
// accepted requests push {due tick, data} into a scoreboard popped when ACK is due.
module tb_wb_ram_slave;

    localparam int NI = 5;

    function automatic int unsigned lat_of(input int i);
        case (i)
            1:       return 3;
            3:       return 2;
            4:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned per_of(input int i);
        return (i == 2) ? 4 : 0;
    endfunction

    function automatic bit rnd_of(input int i);
        return (i == 3);
    endfunction

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    typedef struct {
        bit          we;
        logic [12:0] adr;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [NI];
    logic        cyc   [NI];
    logic        stb   [NI];
    logic        we    [NI];
    logic [12:0] adr   [NI];
    logic [15:0] dat_m [NI];
    logic [15:0] dat_s [NI];
    logic        stall [NI];
    logic        ack   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wb_ram_slave #(
            .AW          (13),
            .DW          (16),
            .LATENCY     (lat_of(g)),
            .STALL_PERIOD(per_of(g)),
            .STALL_RANDOM(rnd_of(g))
        ) u_dut (
            .clk_i  (clk),
            .rst_i  (rst[g]),
            .cyc_i  (cyc[g]),
            .stb_i  (stb[g]),
            .we_i   (we[g]),
            .adr_i  (adr[g]),
            .dat_m_i(dat_m[g]),
            .dat_s_o(dat_s[g]),
            .stall_o(stall[g]),
            .ack_o  (ack[g])
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          tick_n   = 0;
    int          n_acks   = 0;
    int          n_acc    = 0;
    exp_t        sb [$];
    int          cnt_m  [NI];
    logic [15:0] lfsr_m [NI];
    logic [15:0] ref_mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", name, act, exp, tick_n);
        end
    endtask

    // One bus cycle on instance k: check outputs at the falling edge, drive the
    // next inputs, check stall against the bench's own stall model, then book
    // any accept in the scoreboard and advance the model to the next edge.
    task automatic tick(input int k, input bit r, input bit c, input bit s, input bit w,
                        input logic [12:0] a, input logic [15:0] d, input logic [15:0] exp_d,
                        output bit acc, output bit st);
        bit   exp_ack;
        bit   exp_st;
        exp_t e;
        @(negedge clk);
        tick_n++;
        exp_ack = (sb.size() > 0) && (sb[0].due == tick_n);
        chk("ack", 32'(ack[k]), 32'(exp_ack));
        if (ack[k]) n_acks++;
        if (exp_ack) begin
            e = sb.pop_front();
            chk("dat_s", 32'(dat_s[k]), 32'(e.dat));
        end
        rst[k]   = r;
        cyc[k]   = c;
        stb[k]   = s;
        we[k]    = w;
        adr[k]   = a;
        dat_m[k] = d;
        if (r || !c) sb.delete();
        if (rnd_of(k)) exp_st = c && lfsr_m[k][0] && lfsr_m[k][1];
        else if (per_of(k) >= 2) exp_st = c && (cnt_m[k] == int'(per_of(k)) - 1);
        else exp_st = 1'b0;
        #1;
        st = stall[k];
        chk("stall", 32'(st), 32'(exp_st));
        acc = c && s && !st && !r;
        if (acc) begin
            n_acc++;
            e.due = tick_n + int'(lat_of(k));
            e.dat = exp_d;
            sb.push_back(e);
        end
        if (r) begin
            cnt_m[k]  = 0;
            lfsr_m[k] = 16'hACE1;
        end else if (c) begin
            lfsr_m[k] = {lfsr_m[k][14:0],
                         lfsr_m[k][15] ^ lfsr_m[k][13] ^ lfsr_m[k][12] ^ lfsr_m[k][10]};
            if (per_of(k) >= 2) cnt_m[k] = (cnt_m[k] == int'(per_of(k)) - 1) ? 0 : cnt_m[k] + 1;
        end else begin
            cnt_m[k] = 0;
        end
    endtask

    // Hold a request until it is accepted (bounded).
    task automatic xfer(input int k, input bit w, input logic [12:0] a, input logic [15:0] d,
                        input logic [15:0] exp_d);
        bit acc_l, st_l;
        acc_l = 1'b0;
        for (int t = 0; t < 16 && !acc_l; t++) begin
            tick(k, 1'b0, 1'b1, 1'b1, w, a, d, exp_d, acc_l, st_l);
        end
        chk("xfer_accept", 32'(acc_l), 32'd1);
    endtask

    task automatic idle(input int k, input bit c, input int n);
        bit acc_l, st_l;
        for (int t = 0; t < n; t++) begin
            tick(k, 1'b0, c, 1'b0, 1'b0, 13'd0, 16'd0, 16'd0, acc_l, st_l);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt [11];
        bit          acc, st;
        int          a0, c0, idx;
        logic [11:0] mask;
        logic [12:0] ra;
        logic [15:0] rd;
        bit          rw;

        vt[0]  = '{1'b1, 13'h0005,  16'h1234, 16'h0000};
        vt[1]  = '{1'b0, 13'h0005,  16'h0000, 16'h1234};
        vt[2]  = '{1'b1, 13'h1FFF,  16'hBEEF, 16'h0000};
        vt[3]  = '{1'b1, 13'h0000,  16'h0001, 16'h0000};
        vt[4]  = '{1'b0, 13'h1FFF,  16'h0000, 16'hBEEF};
        vt[5]  = '{1'b0, 13'h0000,  16'h0000, 16'h0001};
        vt[6]  = '{1'b1, 13'h0005,  16'hFFFF, 16'h0000};
        vt[7]  = '{1'b0, 13'h0005,  16'h0000, 16'hFFFF};
        vt[8]  = '{1'b0, 13'h0005,  16'h0000, 16'hFFFF};
        vt[9]  = '{1'b1, 13'h0AAA,  16'h5A5A, 16'h0000};
        vt[10] = '{1'b0, 13'h0AAA,  16'h0000, 16'h5A5A};

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = '0;   dat_m[i] = '0;
            cnt_m[i] = 0;  lfsr_m[i] = 16'hACE1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_ack", 32'(ack[i]), 32'd0);
            chk("reset_dat_s", 32'(dat_s[i]), 32'd0);
            chk("reset_stall", 32'(stall[i]), 32'd0);
            rst[i] = 1'b0;
        end

        // Table vectors back-to-back on the default instance.
        for (int i = 0; i < 11; i++) begin
            tick(0, 1'b0, 1'b1, 1'b1, vt[i].we, vt[i].adr, vt[i].wd, vt[i].exp, acc, st);
            chk("vec_accept", 32'(acc), 32'd1);
        end
        idle(0, 1'b1, 2);
        idle(0, 1'b0, 1);

        // Pipelined burst, LATENCY=3.
        for (int i = 0; i < 8; i++) begin
            tick(1, 1'b0, 1'b1, 1'b1, 1'b1, 13'(i), 16'(16'h100 + i), 16'h0, acc, st);
        end
        idle(1, 1'b1, 3);
        a0 = n_acks;
        for (int i = 0; i < 8; i++) begin
            tick(1, 1'b0, 1'b1, 1'b1, 1'b0, 13'(i), 16'h0, 16'(16'h100 + i), acc, st);
            chk("burst_accept", 32'(acc), 32'd1);
        end
        idle(1, 1'b1, 4);
        chk("burst_ack_count", 32'(n_acks - a0), 32'd8);

        // Reset with two reads in flight; CYC stays high so only reset can clear them.
        tick(1, 1'b0, 1'b1, 1'b1, 1'b0, 13'd2, 16'h0, 16'h0102, acc, st);
        tick(1, 1'b0, 1'b1, 1'b1, 1'b0, 13'd3, 16'h0, 16'h0103, acc, st);
        tick(1, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 16'h0, 16'h0, acc, st);
        tick(1, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 16'h0, 16'h0, acc, st);
        chk("rst_dat_s", 32'(dat_s[1]), 32'd0);
        idle(1, 1'b1, 3);
        xfer(1, 1'b0, 13'd3, 16'h0, 16'h0103);
        idle(1, 1'b1, 4);
        idle(1, 1'b0, 1);

        // Periodic stall, STALL_PERIOD=4: 12 cycles of STB.
        a0 = n_acks;
        idx = 0;
        mask = '0;
        for (int c = 0; c < 12; c++) begin
            tick(2, 1'b0, 1'b1, 1'b1, 1'b1, 13'(idx), 16'(16'hA000 + idx), 16'h0, acc, st);
            mask[c] = st;
            if (acc) idx++;
        end
        idle(2, 1'b1, 1);
        chk("period_stall_mask", 32'(mask), 32'h888);
        chk("period_accepts", 32'(idx), 32'd9);
        chk("period_ack_count", 32'(n_acks - a0), 32'd9);
        idle(2, 1'b0, 1);
        for (int i = 0; i < 9; i++) xfer(2, 1'b0, 13'(i), 16'h0, 16'(16'hA000 + i));
        idle(2, 1'b1, 2);
        idle(2, 1'b0, 1);

        // Random stall, LATENCY=2: reference-model traffic under one long CYC.
        a0 = n_acks;
        c0 = n_acc;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'($urandom);
            xfer(3, 1'b1, 13'(i), ref_mem[i], 16'h0);
        end
        for (int i = 0; i < 1000; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 13'($urandom_range(0, 15));
            rd = 16'($urandom);
            xfer(3, rw, ra, rd, rw ? 16'h0 : ref_mem[ra[3:0]]);
            if (rw) ref_mem[ra[3:0]] = rd;
            if ($urandom_range(0, 3) == 0) idle(3, 1'b1, 1);
        end
        idle(3, 1'b1, 4);
        chk("random_ack_eq_accept", 32'(n_acks - a0), 32'(n_acc - c0));
        idle(3, 1'b0, 1);

        // Abort, LATENCY=4: drop CYC right after three read accepts.
        for (int i = 0; i < 3; i++) begin
            tick(4, 1'b0, 1'b1, 1'b1, 1'b1, 13'(i), 16'(16'h4400 + i), 16'h0, acc, st);
        end
        idle(4, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            tick(4, 1'b0, 1'b1, 1'b1, 1'b0, 13'(i), 16'h0, 16'(16'h4400 + i), acc, st);
        end
        tick(4, 1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 16'h0, 16'h0, acc, st);
        a0 = n_acks;
        idle(4, 1'b0, 2);
        idle(4, 1'b1, 6);
        idle(4, 1'b0, 1);
        chk("abort_no_ack", 32'(n_acks - a0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Pipelined Wishbone B4 responder: a single-port word RAM behind the J1 bus that accepts one request per cycle, acknowledges each accepted request a fixed number of cycles later, and can inject STALL cycles on a deterministic or pseudo-random pattern. It is the slave end of the bus used by the J1 core. It also serves as the stress target the bus protocol checker runs against in simulation.

## Interface
- `AW`, 13, word-address width; memory holds 2**AW words.
- `DW`, 16, data width.
- `LATENCY`, 1, cycles from accept to ACK; legal range 1..4.
- `STALL_PERIOD`, 0, periodic stall: 0 = never, N ≥ 2 = STALL high one cycle in every N cycles of an active CYC.
- `STALL_RANDOM`, 0, 1 = ignore STALL_PERIOD and use the LFSR pattern.

Ports:
- `clk`, in, 1, bus clock.
- `rst`, in, 1, synchronous, active-high reset.
- `cyc`, in, 1, bus cycle valid.
- `stb`, in, 1, request strobe.
- `we`, in, 1, 1 = write.
- `adr`, in, AW, word address.
- `dat_m`, in, DW, write data from the master.
- `dat_s`, out, DW, read data to the master.
- `stall`, out, 1, request not accepted this cycle.
- `ack`, out, 1, one pulse per accepted request.

## Operation
- **Accept** = `cyc && stb && !stall` in the same cycle.
- **Write accept:** `mem[adr] <= dat_m` at that edge. The ACK carries `dat_s = 0`.
- **Read accept:** `mem[adr]` is captured at that edge. The ACK carries that value.
- Read one cycle after a write to the same address returns the new data.
- **Response pipeline:** LATENCY stages of {valid, data}.
  - `v[0] <= accept`
  - `v[i] <= v[i-1] && cyc`
  - Stage 0 also clears when `cyc` is low.
- `ack = v[LATENCY-1]` and `dat_s = d[LATENCY-1]`, both registered.
- No request is ever dropped while `cyc` stays high. ACKs come out in accept order, one per accept.
- **CYC deasserted (abort):** every pending response is discarded at the next edge. No stale ACK appears in a later cycle.
- **Stall generator:**
  - **Periodic:** counter `cnt` counts edges with `cyc` high and resets to 0 when `cyc` is low. `stall = cyc && (cnt == STALL_PERIOD-1)`; `cnt` wraps to 0 after that value.
  - **Random:** 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1. It advances every cycle `cyc` is high and holds otherwise. `stall = cyc && lfsr[0] && lfsr[1]`, about 25 %.
  - `stall` is always 0 while `cyc` is low.
- **Reset:**
  - `ack = 0`, `dat_s = 0`, `stall = 0`.
  - All pipeline valids cleared, `cnt = 0`, LFSR = 0xACE1.
  - RAM contents are not reset.
- **Reset mid-transfer:** all pending ACKs are lost, and the master must restart the cycle.

## Timing
- Accept at edge k → ACK high in the cycle after edge k+LATENCY-1. With LATENCY = 1, ACK is in the cycle directly after the accept.
- Throughput is one request per cycle when not stalled.
- ACK may still be high in the first cycle after `cyc` falls. Masters ignore it.
- `stall` depends only on registered state and `cyc`. There is no combinational path from `stb`, `adr` or `we`.
- Back-to-back accept plus ACK in the same cycle is legal for any LATENCY.

## Structure
- **Shared package `wb_pkg`:**
  - `LFSR_SEED = 16'hACE1`
  - `LFSR_TAPS = 16'hB400`
  - `MAX_LATENCY = 4`
- **Sub-module `wb_stall_gen`:** parameters STALL_PERIOD and STALL_RANDOM; inputs `clk`, `rst`, `cyc`; output `stall`.
- **Top level:** RAM array, accept decode and response pipeline.

## Test plan
- **Single write then read:** defaults; write 0x1234 to adr 5, then read adr 5 → ACK one cycle after each accept, read `dat_s = 0x1234`, write `dat_s = 0`.
- **Pipelined burst:** LATENCY = 3; 8 consecutive reads of adr 0..7 (preloaded value = adr+0x100), one accept per cycle → 8 ACKs in consecutive cycles starting 3 cycles after the first accept, data 0x100..0x107 in order.
- **Periodic stall:** STALL_PERIOD = 4; hold `stb` for 12 cycles → STALL on cycles 3, 7 and 11 of CYC; exactly 9 ACKs; the stalled request's address is re-issued and accepted next cycle.
- **Random stall:** STALL_RANDOM = 1; 1000 random transfers with the protocol checker bound → zero checker errors, ACK count equals accept count, and read data matches a reference model.
- **Abort:** LATENCY = 4; accept 3 reads, drop `cyc` the cycle after the last accept → no ACK appears from the cycle after `cyc` falls onward, including after `cyc` rises again.
- **Reset mid-burst:** assert `rst` for one cycle with 2 responses pending → next cycle `ack = 0`, `stall = 0`, `dat_s = 0`; a subsequent read of previously written data still returns that data.
